// File: rtl/store_drain_buffer.sv
// store_drain_buffer: posted-store FIFO between the MEM stage and a
// single-port data memory. Stores enqueue in one cycle and drain one per
// cycle; loads own the port ahead of drains unless the queued drain has
// waited STARVE load cycles. A load matching a queued store stalls until
// no queued store matches it.
// Build option: define STORE_FWD_EN to forward the youngest matching entry
// to the load when that entry is a `DWORD store.

`ifndef DWORD
`define DWORD        3'd0
`define WORD_LOW     3'd1
`define WORD_HIGH    3'd2
`define BYTE_LOWEST  3'd3
`define BYTE_LOW     3'd4
`define BYTE_HIGH    3'd5
`define BYTE_HIGHEST 3'd6
`endif

module store_drain_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned STARVE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StReq,
    input  logic [ADDR_W-1:0] StAddr,
    input  logic [31:0]       StData,
    input  logic [2:0]        StLen,
    output logic              StStall,
    input  logic              LdReq,
    input  logic [ADDR_W-1:0] LdAddr,
    output logic [31:0]       LdData,
    output logic              LdStall,
    output logic [ADDR_W-1:0] DmAddr,
    output logic              DmWrite,
    output logic [31:0]       DmWData,
    output logic [2:0]        DmLen,
    input  logic [31:0]       DmRData,
    output logic              Empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE + 1);
    localparam logic [CW-1:0] FULL       = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE);

    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_LOAD,
        PORT_DRAIN
    } portSel_t;

    logic [ADDR_W-1:0] addrQ [DEPTH];
    logic [31:0]       dataQ [DEPTH];
    logic [2:0]        lenQ  [DEPTH];

    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;

    logic     hit;
    logic     fwdOk;
    logic     starved;
    logic     stAccept;
    logic     drainGo;
    portSel_t portSel;
`ifdef STORE_FWD_EN
    logic [PW-1:0] hitIdx;
`endif

    assign starved  = (starve >= STARVE_LIM);
    assign stAccept = StReq && (count != FULL);
    assign drainGo  = (portSel == PORT_DRAIN);
    assign StStall  = !rst && (count == FULL);
    assign Empty    = rst || (count == '0);

    // Address match against valid entries, scanned oldest to youngest so the youngest match wins.
    always_comb begin
        hit = 1'b0;
`ifdef STORE_FWD_EN
        hitIdx = '0;
`endif
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count) && (addrQ[rdPtr + PW'(k)] == LdAddr)) begin
                hit = 1'b1;
`ifdef STORE_FWD_EN
                hitIdx = rdPtr + PW'(k);
`endif
            end
        end
`ifdef STORE_FWD_EN
        fwdOk = hit && (lenQ[hitIdx] == `DWORD);
`else
        fwdOk = 1'b0;
`endif
    end

    // Port arbitration: a non-hitting load wins unless the drain is starved.
    always_comb begin
        portSel = PORT_IDLE;
        if (LdReq && !hit && !starved) begin
            portSel = PORT_LOAD;
        end else if (count != '0) begin
            portSel = PORT_DRAIN;
        end
    end

    // Memory port drive, load result and stall generation.
    always_comb begin
        DmAddr  = LdAddr;
        DmWrite = 1'b0;
        DmWData = dataQ[rdPtr];
        DmLen   = lenQ[rdPtr];
        LdData  = DmRData;
        LdStall = 1'b0;
        if (!rst && drainGo) begin
            DmAddr  = addrQ[rdPtr];
            DmWrite = 1'b1;
        end
`ifdef STORE_FWD_EN
        if (fwdOk) begin
            LdData = dataQ[hitIdx];
        end
`endif
        // A load issued alongside a store is never satisfied.
        if (!rst && LdReq) begin
            LdStall = StReq || ((portSel != PORT_LOAD) && !fwdOk);
        end
    end

    // Pointer, occupancy and starvation bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            starve <= '0;
        end else begin
            if (stAccept) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (drainGo) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({stAccept, drainGo})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drainGo || (count == '0)) begin
                starve <= '0;
            end else if (portSel == PORT_LOAD) begin
                starve <= starve + SW'(1);
            end
        end
    end

    // Entry storage; contents need no reset because validity comes from count.
    always_ff @(posedge clk) begin
        if (!rst && stAccept) begin
            addrQ[wrPtr] <= StAddr;
            dataQ[wrPtr] <= StData;
            lenQ[wrPtr]  <= StLen;
        end
    end

endmodule

// File: tb/tb_store_drain_buffer.sv
// Bench for store_drain_buffer: directed scenarios plus random traffic.
// Expected memory writes are the accepted stores in order; expected load
// results are the architectural memory value at load issue.
module tb_store_drain_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 7;
    localparam int STARVE = 8;
    localparam int BUDGET = DEPTH * (STARVE + 1) + 4;
    localparam logic [2:0] L_DWORD    = 3'd0;
    localparam logic [2:0] L_BYTE_LOW = 3'd4;
`ifdef STORE_FWD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              StReq = 1'b0;
    logic [ADDR_W-1:0] StAddr = '0;
    logic [31:0]       StData = '0;
    logic [2:0]        StLen = '0;
    logic              StStall;
    logic              LdReq = 1'b0;
    logic [ADDR_W-1:0] LdAddr = '0;
    logic [31:0]       LdData;
    logic              LdStall;
    logic [ADDR_W-1:0] DmAddr;
    logic              DmWrite;
    logic [31:0]       DmWData;
    logic [2:0]        DmLen;
    logic [31:0]       DmRData;
    logic              Empty;

    store_drain_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .STARVE(STARVE)) dut (
        .clk(clk), .rst(rst),
        .StReq(StReq), .StAddr(StAddr), .StData(StData), .StLen(StLen), .StStall(StStall),
        .LdReq(LdReq), .LdAddr(LdAddr), .LdData(LdData), .LdStall(LdStall),
        .DmAddr(DmAddr), .DmWrite(DmWrite), .DmWData(DmWData), .DmLen(DmLen),
        .DmRData(DmRData), .Empty(Empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [2:0]        len;
    } wr_t;

    wr_t         writeQ [$];
    logic [31:0] loadQ  [$];
    logic [31:0] mem     [128];
    logic [31:0] refMem  [128];
    logic [31:0] archMem [128];
    int          total = 0;
    int          bad   = 0;
    wr_t         monE;
    logic [31:0] monExp;

    // Lane placement performed by the data memory.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [2:0] len);
        logic [31:0] r;
        r = old;
        case (len)
            3'd0: r = d;
            3'd1: r[15:0]  = d[15:0];
            3'd2: r[31:16] = d[15:0];
            3'd3: r[7:0]   = d[7:0];
            3'd4: r[15:8]  = d[7:0];
            3'd5: r[23:16] = d[7:0];
            3'd6: r[31:24] = d[7:0];
            default: r = old;
        endcase
        return r;
    endfunction

    assign DmRData = mem[DmAddr];
    always @(posedge clk) begin
        if (DmWrite) mem[DmAddr] <= merge(mem[DmAddr], DmWData, DmLen);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name, input int waited);
        total++;
        bad++;
        $display("FAIL %s: waited %0d cycles, limit %0d", name, waited, BUDGET);
    endtask

    // Monitor: per-cycle status checks and scoreboard pops.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ststall", 32'(StStall), 32'd0);
            chk("rst_ldstall", 32'(LdStall), 32'd0);
            chk("rst_dmwrite", 32'(DmWrite), 32'd0);
            chk("rst_empty",   32'(Empty),   32'd1);
        end else begin
            chk("ststall", 32'(StStall), 32'(writeQ.size() == DEPTH));
            chk("empty",   32'(Empty),   32'(writeQ.size() == 0));
            if (LdReq && StReq) chk("ld_with_st_stall", 32'(LdStall), 32'd1);
            if (!DmWrite) chk("dmaddr_idle", 32'(DmAddr), 32'(LdAddr));
            if (DmWrite) begin
                if (writeQ.size() == 0) begin
                    chk("unexpected_write_addr", 32'(DmAddr), 32'hFFFF_FFFF);
                end else begin
                    monE = writeQ.pop_front();
                    chk("wr_addr", 32'(DmAddr), 32'(monE.addr));
                    chk("wr_data", DmWData, monE.data);
                    chk("wr_len",  32'(DmLen), 32'(monE.len));
                    refMem[monE.addr] = merge(refMem[monE.addr], monE.data, monE.len);
                end
            end
            if (LdReq && !StReq && !LdStall) begin
                if (loadQ.size() == 0) begin
                    chk("unexpected_load_done", 32'(LdAddr), 32'hFFFF_FFFF);
                end else begin
                    monExp = loadQ.pop_front();
                    chk("ld_data", LdData, monExp);
                end
            end
        end
    end

    task automatic accept(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [2:0] l);
        writeQ.push_back('{addr: a, data: d, len: l});
        archMem[a] = merge(archMem[a], d, l);
    endtask

    // Issue one store (optionally with a missing load holding the port); retry while stalled.
    task automatic storeOp(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [2:0] l,
                           input logic blockPort, output int waited);
        logic stalled;
        StReq = 1'b1; StAddr = a; StData = d; StLen = l;
        if (blockPort) begin
            LdReq = 1'b1; LdAddr = 7'h7F;
        end
        waited = 0;
        forever begin
            @(negedge clk);
            stalled = StStall;
            @(posedge clk);
            if (!stalled) begin
                accept(a, d, l);
                break;
            end
            waited++;
            if (waited > BUDGET) begin
                timeoutFail("store_timeout", waited);
                break;
            end
        end
        #1;
        StReq = 1'b0;
        LdReq = 1'b0;
    endtask

    // Issue one load; hold it until not stalled.
    task automatic loadOp(input logic [ADDR_W-1:0] a, output int stalls, output logic [31:0] data);
        logic done;
        loadQ.push_back(archMem[a]);
        LdReq = 1'b1; LdAddr = a;
        stalls = 0;
        data = '0;
        forever begin
            @(negedge clk);
            done = !LdStall;
            data = LdData;
            @(posedge clk);
            if (done) break;
            stalls++;
            if (stalls > BUDGET) begin
                timeoutFail("load_timeout", stalls);
                break;
            end
        end
        #1;
        LdReq = 1'b0;
    endtask

    task automatic waitEmpty(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (Empty) break;
            n++;
            if (n > BUDGET) begin
                timeoutFail(name, n);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          st;
        logic [31:0] d;
        int          idx;
        logic        stalled;
        int          r;
        logic [ADDR_W-1:0] a;

        for (int i = 0; i < 128; i++) begin
            mem[i] = '0; refMem[i] = '0; archMem[i] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // T1: four DWORD stores, drained behind them.
        for (int i = 1; i <= 4; i++) begin
            storeOp(7'(i), 32'h1000_0000 + 32'(i), L_DWORD, 1'b0, w);
            chk("t1_no_ststall", 32'(w), 32'd0);
        end
        @(negedge clk);
        chk("t1_last_drain", 32'(DmWrite), 32'd1);
        chk("t1_last_addr",  32'(DmAddr),  32'd4);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_empty", 32'(Empty), 32'd1);
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) begin
            loadOp(7'(i), st, d);
            chk("t1_ld_stalls", 32'(st), 32'd0);
            chk("t1_ld_data", d, 32'h1000_0000 + 32'(i));
        end

        // T2: stores paired with a missing load; fifth stalls, starvation drains at cycle 9.
        idx = 0;
        StReq = 1'b1; StAddr = 7'h40; StData = 32'hA0; StLen = L_DWORD;
        LdReq = 1'b1; LdAddr = 7'h7F;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            chk("t2_dmwrite", 32'(DmWrite), 32'(c == 9));
            chk("t2_ststall", 32'(StStall), 32'(c >= 4 && c <= 9));
            stalled = StStall;
            @(posedge clk);
            if (!stalled) begin
                accept(StAddr, StData, StLen);
                idx++;
            end
            #1;
            if (idx < 5) begin
                StAddr = 7'h40 + 7'(idx);
                StData = 32'hA0 + 32'(idx);
            end else begin
                StReq = 1'b0;
            end
        end
        chk("t2_all_accepted", 32'(idx), 32'd5);
        StReq = 1'b0; LdReq = 1'b0;
        waitEmpty("t2_drain_timeout");

        // T3: DWORD store then load of the same word.
        storeOp(7'h10, 32'hDEAD_BEEF, L_DWORD, 1'b0, w);
        loadOp(7'h10, st, d);
        chk("t3_stalls", 32'(st), (FWD != 0) ? 32'd0 : 32'd1);
        chk("t3_data", d, 32'hDEAD_BEEF);
        waitEmpty("t3_drain_timeout");

        // T4: byte store then load; never forwarded.
        storeOp(7'h20, 32'h0000_00AB, L_BYTE_LOW, 1'b0, w);
        loadOp(7'h20, st, d);
        chk("t4_stalls", 32'(st), 32'd1);
        chk("t4_data", d, 32'h0000_AB00);
        waitEmpty("t4_drain_timeout");

        // T5: two queued stores to one word; youngest wins.
        storeOp(7'h30, 32'h1, L_DWORD, 1'b1, w);
        storeOp(7'h30, 32'h2, L_DWORD, 1'b1, w);
        loadOp(7'h30, st, d);
        chk("t5_stalls", 32'(st), (FWD != 0) ? 32'd0 : 32'd2);
        chk("t5_data", d, 32'h2);
        waitEmpty("t5_drain_timeout");

        // T6: reset discards queued stores.
        for (int i = 0; i < 3; i++) storeOp(7'h60 + 7'(i), 32'hC0DE_0000 + 32'(i), L_DWORD, 1'b1, w);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_dmwrite", 32'(DmWrite), 32'd0);
        chk("t6_rst_empty",   32'(Empty),   32'd1);
        @(posedge clk);
        writeQ.delete();
        for (int i = 0; i < 128; i++) archMem[i] = refMem[i];
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_empty_after", 32'(Empty), 32'd1);
            chk("t6_no_write",    32'(DmWrite), 32'd0);
            @(posedge clk); #1;
        end
        loadOp(7'h60, st, d);
        chk("t6_ld_data", d, 32'h0);

        // Random traffic over a small address window to create hits.
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            a = 7'($urandom_range(0, 7));
            if (r < 45) begin
                storeOp(a, $urandom, 3'($urandom_range(0, 6)), 1'b0, w);
            end else if (r < 85) begin
                loadOp(a, st, d);
            end else begin
                @(posedge clk); #1;
            end
        end
        waitEmpty("final_drain_timeout");
        chk("final_writes_left", 32'(writeQ.size()), 32'd0);
        chk("final_loads_left",  32'(loadQ.size()),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
